// File: rtl/simon_pkg.sv
// simon_pkg: constants shared by the Simon button path, the game FSM and the
// LED driver.
//   NBTN       - number of game buttons
//   BTN_*      - event code assigned to each coloured button
package simon_pkg;

  localparam int NBTN = 4;

  localparam int BTN_GREEN  = 0;
  localparam int BTN_RED    = 1;
  localparam int BTN_YELLOW = 2;
  localparam int BTN_BLUE   = 3;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with an explicit occupancy counter.
// There is no write-to-read bypass. A word pushed into an empty FIFO becomes
// visible on rdata one cycle later.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   clr          - synchronous flush; the push and pop of that cycle are discarded
//   push, wdata  - write request and data; refused when full unless popping
//   pop          - read request; ignored when empty
//   rdata        - word at the head of the FIFO
//   full, empty  - occupancy flags derived from level
//   level        - current number of stored words (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);
  assign rdata = mem[rd_ptr];

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two. Occupancy is
  // tracked by level, so full and empty never need pointer comparison.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// button_event_queue: turns debounced Simon button levels into press events
// and queues them for the game controller.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   btn                 - debounced button levels, 1 = pressed
//   clr                 - synchronous flush of the queue and the overflow flag
//   evt_valid/evt_code  - head event and its button index
//   evt_ready           - consumer accepts the head event
//   collide             - one-cycle pulse when two or more buttons rose together
//   overflow            - sticky flag: a press was dropped because the queue was full
//   level               - current queue occupancy
module button_event_queue #(
  parameter int NBTN  = simon_pkg::NBTN,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NBTN-1:0]             btn,
  input  logic                        clr,
  output logic                        evt_valid,
  output logic [$clog2(NBTN)-1:0]     evt_code,
  input  logic                        evt_ready,
  output logic                        collide,
  output logic                        overflow,
  output logic [$clog2(DEPTH):0]      level
);

  import simon_pkg::*;

  localparam int CW = $clog2(NBTN);

  logic [NBTN-1:0] prev;
  logic [NBTN-1:0] rise;
  logic            any_rise;
  logic            multi_rise;
  logic [CW-1:0]   push_code;
  logic            fifo_full;
  logic            fifo_empty;
  logic            pop;

  assign rise       = btn & ~prev;
  assign any_rise   = |rise;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_rise = |(rise & (rise - 1'b1));
  assign evt_valid  = !fifo_empty;
  assign pop        = evt_valid && evt_ready;

  // Lowest set index wins; scanning downward lets the lowest hit overwrite.
  always_comb begin
    push_code = CW'(BTN_GREEN);
    for (int i = NBTN - 1; i >= 0; i--) begin
      if (rise[i]) push_code = CW'(i);
    end
  end

  // prev resets to all ones so a button held through reset is not an event.
  // overflow only sets for a refused push; a clr in the same cycle wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev     <= '1;
      collide  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      prev    <= btn;
      collide <= multi_rise;
      if (clr)
        overflow <= 1'b0;
      else if (any_rise && fifo_full && !pop)
        overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (CW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (any_rise),
    .wdata (push_code),
    .pop   (pop),
    .rdata (evt_code),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

endmodule

// File: tb/tb_button_event_queue.sv
// tb_button_event_queue: directed checks of the button event queue covering
// reset, collisions, overflow, push on a full queue with a pop, clr, and
// asynchronous reset.
module tb_button_event_queue;

  import simon_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic       clr = 1'b0;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       evt_ready = 1'b0;
  logic       collide;
  logic       overflow;
  logic [2:0] level;

  int compared = 0;
  int mismatched = 0;

  button_event_queue #(.NBTN(4), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .clr       (clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .collide   (collide),
    .overflow  (overflow),
    .level     (level)
  );

  always #5 clk = ~clk;

  // Advance one clock; outputs settle 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Press a single button for one cycle, then release it for one cycle.
  task automatic press(input int code);
    btn = 4'(1 << code);
    tick();
    btn = 4'b0000;
    tick();
  endtask

  task automatic test_reset();
    btn = 4'b0100;
    rst_n = 1'b0;
    #12;
    compared++; if (evt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid: got %b want 0", evt_valid); end
    compared++; if (level !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_level: got %0d want 0", level); end
    compared++; if (overflow !== 1'b0 || collide !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_flags: got ovf=%b col=%b want 0/0", overflow, collide); end
    compared++; if (evt_code !== 2'd0) begin mismatched++; $display("[TB] FAIL reset_code: got %0d want 0", evt_code); end
    rst_n = 1'b1;
    repeat (3) tick();
    compared++; if (evt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL held_no_event: got %b want 0", evt_valid); end
    btn = 4'b0000;
    tick();
    compared++; if (evt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL release_no_event: got %b want 0", evt_valid); end
    btn = 4'b0100;
    tick();
    compared++; if (evt_valid !== 1'b1 || evt_code !== 2'(BTN_YELLOW)) begin mismatched++; $display("[TB] FAIL repress_event: got v=%b code=%0d want v=1 code=2", evt_valid, evt_code); end
    compared++; if (level !== 3'd1) begin mismatched++; $display("[TB] FAIL repress_level: got %0d want 1", level); end
    evt_ready = 1'b1;
    tick();
    compared++; if (evt_valid !== 1'b0 || level !== 3'd0) begin mismatched++; $display("[TB] FAIL repress_drain: got v=%b lvl=%0d want 0/0", evt_valid, level); end
    evt_ready = 1'b0;
    btn = 4'b0000;
    tick();
  endtask

  task automatic test_collide();
    evt_ready = 1'b1;
    btn = 4'b1010;
    tick();
    compared++; if (collide !== 1'b1) begin mismatched++; $display("[TB] FAIL collide_pulse: got %b want 1", collide); end
    compared++; if (evt_valid !== 1'b1 || evt_code !== 2'(BTN_RED)) begin mismatched++; $display("[TB] FAIL collide_code: got v=%b code=%0d want v=1 code=1", evt_valid, evt_code); end
    compared++; if (level !== 3'd1) begin mismatched++; $display("[TB] FAIL collide_level1: got %0d want 1", level); end
    tick();
    compared++; if (collide !== 1'b0) begin mismatched++; $display("[TB] FAIL collide_one_cycle: got %b want 0", collide); end
    compared++; if (level !== 3'd0 || evt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL collide_drained: got lvl=%0d v=%b want 0/0", level, evt_valid); end
    btn = 4'b0000;
    evt_ready = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    int exp_codes [4] = '{0, 1, 2, 3};
    evt_ready = 1'b0;
    press(BTN_GREEN);
    press(BTN_RED);
    press(BTN_YELLOW);
    press(BTN_BLUE);
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_before: got %b want 0", overflow); end
    press(BTN_GREEN);
    compared++; if (level !== 3'd4) begin mismatched++; $display("[TB] FAIL ovf_level: got %0d want 4", level); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_set: got %b want 1", overflow); end
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++; if (evt_valid !== 1'b1 || evt_code !== 2'(exp_codes[i])) begin mismatched++; $display("[TB] FAIL ovf_drain%0d: got v=%b code=%0d want v=1 code=%0d", i, evt_valid, evt_code, exp_codes[i]); end
      tick();
    end
    compared++; if (evt_valid !== 1'b0 || level !== 3'd0) begin mismatched++; $display("[TB] FAIL ovf_empty: got v=%b lvl=%0d want 0/0", evt_valid, level); end
    compared++; if (overflow !== 1'b1) begin mismatched++; $display("[TB] FAIL ovf_sticky: got %b want 1", overflow); end
    evt_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL ovf_clr: got %b want 0", overflow); end
  endtask

  task automatic test_full_pop();
    int exp_codes [4] = '{1, 3, 0, 2};
    evt_ready = 1'b0;
    press(BTN_GREEN);
    press(BTN_RED);
    press(BTN_BLUE);
    press(BTN_GREEN);
    compared++; if (level !== 3'd4) begin mismatched++; $display("[TB] FAIL fullpop_fill: got %0d want 4", level); end
    btn = 4'b0100;
    evt_ready = 1'b1;
    tick();
    btn = 4'b0000;
    evt_ready = 1'b0;
    compared++; if (level !== 3'd4) begin mismatched++; $display("[TB] FAIL fullpop_level: got %0d want 4", level); end
    compared++; if (overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL fullpop_ovf: got %b want 0", overflow); end
    tick();
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      compared++; if (evt_valid !== 1'b1 || evt_code !== 2'(exp_codes[i])) begin mismatched++; $display("[TB] FAIL fullpop_drain%0d: got v=%b code=%0d want v=1 code=%0d", i, evt_valid, evt_code, exp_codes[i]); end
      tick();
    end
    compared++; if (evt_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fullpop_empty: got %b want 0", evt_valid); end
    evt_ready = 1'b0;
  endtask

  task automatic test_clr();
    press(BTN_GREEN);
    press(BTN_RED);
    press(BTN_YELLOW);
    compared++; if (level !== 3'd3) begin mismatched++; $display("[TB] FAIL clr_fill: got %0d want 3", level); end
    clr = 1'b1;
    btn = 4'b1000;
    tick();
    clr = 1'b0;
    compared++; if (level !== 3'd0 || evt_valid !== 1'b0 || overflow !== 1'b0) begin mismatched++; $display("[TB] FAIL clr_flush: got lvl=%0d v=%b ovf=%b want 0/0/0", level, evt_valid, overflow); end
    tick();
    compared++; if (evt_valid !== 1'b0 || level !== 3'd0) begin mismatched++; $display("[TB] FAIL clr_no_code3: got v=%b lvl=%0d want 0/0", evt_valid, level); end
    btn = 4'b0000;
    tick();
  endtask

  task automatic test_async_reset();
    press(BTN_RED);
    press(BTN_YELLOW);
    compared++; if (level !== 3'd2) begin mismatched++; $display("[TB] FAIL arst_fill: got %0d want 2", level); end
    #2;
    rst_n = 1'b0;
    #1;
    compared++; if (evt_valid !== 1'b0 || level !== 3'd0) begin mismatched++; $display("[TB] FAIL arst_immediate: got v=%b lvl=%0d want 0/0", evt_valid, level); end
    #1;
    rst_n = 1'b1;
    tick();
    compared++; if (evt_valid !== 1'b0 || level !== 3'd0) begin mismatched++; $display("[TB] FAIL arst_after: got v=%b lvl=%0d want 0/0", evt_valid, level); end
  endtask

  initial begin
    test_reset();
    test_collide();
    test_overflow();
    test_full_pop();
    test_clr();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
